// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit serializer.
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/bit_serializer.sv
// LSB-first parallel-to-serial converter with an idle gap after each frame.
// Optional even-parity bit after the data bits when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             X,
  output logic             busy,
  output logic             last,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_CNT = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST   = 4'(GAP - 1);

  // Handshake: a word transfers on a rising edge where valid && ready; ready is
  // high only in IDLE, so valid and data_in are ignored while a frame or gap runs.

  serializer_pkg::state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             x_q, x_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             frame_done;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    x_d        = x_q;
    last_d     = last_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    frame_done = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      serializer_pkg::IDLE: begin
        if (valid) begin
          state_d = serializer_pkg::SHIFT;
          shreg_d = data_in;
          x_d     = data_in[0];
          cnt_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      serializer_pkg::SHIFT: begin
        if (cnt_q == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = serializer_pkg::PARITY;
          x_d     = par_q;
          last_d  = 1'b1;
`else
          frame_done = 1'b1;
`endif
        end else begin
          // Rotating keeps every captured bit live; the next bit lands in bit 0.
          shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
          x_d     = shreg_d[0];
          cnt_d   = cnt_q + 1'b1;
          last_d  = (cnt_q == PENULT_CNT);
        end
      end
`ifdef SERIALIZER_PARITY_EN
      serializer_pkg::PARITY: begin
        frame_done = 1'b1;
      end
`endif
      serializer_pkg::GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = serializer_pkg::IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = serializer_pkg::IDLE;
        x_d     = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    if (frame_done) begin
      x_d    = 1'b0;
      last_d = 1'b0;
      if (GAP > 0) begin
        state_d = serializer_pkg::GAP;
        gcnt_d  = 4'd0;
      end else begin
        state_d = serializer_pkg::IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= serializer_pkg::IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= 4'd0;
      x_q     <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      x_q     <= x_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign X         = x_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule
